// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the instruction encoder: op enum, MIPS
// opcode/funct constants, encoding formats and the loader FSM states.
package inst_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_JR, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI,
    OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [2:0] {
    FMT_R, FMT_SHIFT, FMT_JR, FMT_I, FMT_LUI, FMT_J, FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_RUN, ST_DONE
  } state_e;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= 5'(OP_JAL);
  endfunction

endpackage

// File: rtl/inst_enc_word.sv
// Combinational field-to-word MIPS encoder. Illegal ops encode to all-ones
// when INST_ENCODER_ILLEGAL_TRAP_EN is defined, otherwise to a NOP.
module inst_enc_word
  import inst_enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] jimm,
  output logic [31:0] word
);

`ifdef INST_ENCODER_ILLEGAL_TRAP_EN
  localparam logic [31:0] ILLEGAL_WORD = '1;
`else
  localparam logic [31:0] ILLEGAL_WORD = '0;
`endif

  fmt_e       fmt;
  logic [5:0] code;

  always_comb begin
    fmt  = FMT_BAD;
    code = '0;
    case (op)
      OP_ADD:   begin fmt = FMT_R;     code = FN_ADD;   end
      OP_ADDU:  begin fmt = FMT_R;     code = FN_ADDU;  end
      OP_SUB:   begin fmt = FMT_R;     code = FN_SUB;   end
      OP_SUBU:  begin fmt = FMT_R;     code = FN_SUBU;  end
      OP_AND:   begin fmt = FMT_R;     code = FN_AND;   end
      OP_OR:    begin fmt = FMT_R;     code = FN_OR;    end
      OP_XOR:   begin fmt = FMT_R;     code = FN_XOR;   end
      OP_NOR:   begin fmt = FMT_R;     code = FN_NOR;   end
      OP_SLT:   begin fmt = FMT_R;     code = FN_SLT;   end
      OP_SLTU:  begin fmt = FMT_R;     code = FN_SLTU;  end
      OP_SLL:   begin fmt = FMT_SHIFT; code = FN_SLL;   end
      OP_SRL:   begin fmt = FMT_SHIFT; code = FN_SRL;   end
      OP_SRA:   begin fmt = FMT_SHIFT; code = FN_SRA;   end
      OP_SLLV:  begin fmt = FMT_R;     code = FN_SLLV;  end
      OP_SRLV:  begin fmt = FMT_R;     code = FN_SRLV;  end
      OP_SRAV:  begin fmt = FMT_R;     code = FN_SRAV;  end
      OP_JR:    begin fmt = FMT_JR;    code = FN_JR;    end
      OP_ADDI:  begin fmt = FMT_I;     code = OPC_ADDI;  end
      OP_ADDIU: begin fmt = FMT_I;     code = OPC_ADDIU; end
      OP_ANDI:  begin fmt = FMT_I;     code = OPC_ANDI;  end
      OP_ORI:   begin fmt = FMT_I;     code = OPC_ORI;   end
      OP_XORI:  begin fmt = FMT_I;     code = OPC_XORI;  end
      OP_LUI:   begin fmt = FMT_LUI;   code = OPC_LUI;   end
      OP_SLTI:  begin fmt = FMT_I;     code = OPC_SLTI;  end
      OP_SLTIU: begin fmt = FMT_I;     code = OPC_SLTIU; end
      OP_LW:    begin fmt = FMT_I;     code = OPC_LW;    end
      OP_SW:    begin fmt = FMT_I;     code = OPC_SW;    end
      OP_BEQ:   begin fmt = FMT_I;     code = OPC_BEQ;   end
      OP_BNE:   begin fmt = FMT_I;     code = OPC_BNE;   end
      OP_J:     begin fmt = FMT_J;     code = OPC_J;     end
      OP_JAL:   begin fmt = FMT_J;     code = OPC_JAL;   end
      default:  begin fmt = FMT_BAD;   code = '0;        end
    endcase
  end

  // R-type ALU and variable shifts share one layout with shamt forced to zero.
  always_comb begin
    word = ILLEGAL_WORD;
    case (fmt)
      FMT_R:     word = {OPC_SPECIAL, rs, rt, rd, 5'b0, code};
      FMT_SHIFT: word = {OPC_SPECIAL, 5'b0, rt, rd, shamt, code};
      FMT_JR:    word = {OPC_SPECIAL, rs, 15'b0, code};
      FMT_I:     word = {code, rs, rt, imm};
      FMT_LUI:   word = {code, 5'b0, rt, imm};
      FMT_J:     word = {code, jimm};
      default:   word = ILLEGAL_WORD;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streams field-level requests into encoded MIPS words written sequentially
// to IMEM through a small skid buffer. Optional: INST_ENCODER_ILLEGAL_TRAP_EN.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_jimm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  accepted_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic [31:0]       enc_word;
  logic              push, pop, last_write, session_start;

  inst_enc_word u_word (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .imm   (in_imm),
    .jimm  (in_jimm),
    .word  (enc_word)
  );

  always_comb begin
    session_start = (state == ST_IDLE) && start;
    in_ready      = (state == ST_RUN) && (occ != FULL_CNT) && (accepted_cnt != len_q);
    push          = in_valid && in_ready;
    imem_we       = (occ != '0);
    pop           = imem_we && imem_ready;
    last_write    = pop && (remaining == LEN_W'(1));
    imem_addr     = addr_cnt;
    imem_wdata    = imem_we ? mem[rd_ptr] : '0;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (prog_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_write) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt     <= '0;
      remaining    <= '0;
      accepted_cnt <= '0;
      len_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
    end else begin
      if (session_start) begin
        addr_cnt     <= base_addr;
        remaining    <= prog_len;
        len_q        <= prog_len;
        accepted_cnt <= '0;
      end
      if (push) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        accepted_cnt <= accepted_cnt + LEN_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

`ifdef INST_ENCODER_ILLEGAL_TRAP_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                            err_q <= 1'b0;
    else if (session_start)                err_q <= 1'b0;
    else if (push && !op_is_legal(in_op))  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Converts a stream of field-level instruction requests into 32-bit MIPS words and writes them sequentially into instruction memory.
- Implements the same 31-instruction subset the core decodes: R-type ALU/shift ops, jr, the I-type ALU ops, lui, lw, sw, beq, bne, j and jal.
- Sits between the test/boot loader front end and the IMEM write port. It is the producer counterpart of the core's decode stage.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- LEN_W, 10, width of the programme-length counter.
- BUF_DEPTH, 2, entries in the output skid buffer. Legal values: 2 or 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse that begins a load session; ignored unless in IDLE.
- base_addr  in  ADDR_W  first IMEM word address of the session.
- prog_len  in  LEN_W  number of words to write; 0 means an empty session.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready.
- in_op  in  5  operation code, an enum from the package.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate for I-type ops; the word offset for branches.
- in_jimm  in  26  jump target for j/jal.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  IMEM accepts the write when imem_we&imem_ready.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky illegal-op flag; cleared by start.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0. The state machine returns to IDLE and the buffer empties.
- Reset applies mid-session too. Writes already pending in the buffer are discarded.
- IDLE:
  - On start, latch addr_cnt=base_addr and remaining=prog_len, clear err.
  - Go to DONE if prog_len=0, otherwise to RUN.
- RUN:
  - in_ready=1 when buffer is not full and accepted_cnt<prog_len.
  - Each accepted request is encoded combinationally and registered into the buffer. It reaches imem_we one cycle after acceptance (latency 1).
- Output side:
  - imem_we=1 while the buffer is non-empty.
  - imem_wdata and imem_addr are held stable until imem_ready.
  - Each completed write increments addr_cnt (wraps modulo 2^ADDR_W) and decrements remaining.
- Buffer full and empty in the same cycle: simultaneous accept and write are allowed; occupancy stays unchanged.
- Leaving RUN: when remaining reaches 0 after a write, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start arriving during DONE is ignored.
- Encoding rules:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. Shifts sll/srl/sra force rs=0. Variable shifts and ALU ops force shamt=0.
  - jr: {6'h00, rs, 15'b0, 6'h08}.
  - I-type: {opcode, rs, rt, imm}. lui forces rs=0.
  - J-type: {opcode, jimm}.
  - No range checking of fields; only the in_op value is validated.
- Illegal in_op (outside the enum): the request is consumed and counted as one word. The word written depends on the optional feature.

Optional Feature:
- Macro: INST_ENCODER_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal op sets err=1.
  - Writes the word 32'hFFFF_FFFF so the core traps on it.
- Undefined:
  - err is tied to 0.
  - An illegal op is written as NOP, 32'h0000_0000.

Decomposition:
- Package inst_enc_pkg holds:
  - the op_e enum (5 bits);
  - opcode constants (ADDI=6'h08, ADDIU=6'h09, ANDI=6'h0C, ORI=6'h0D, XORI=6'h0E, LUI=6'h0F, SLTI=6'h0A, SLTIU=6'h0B, LW=6'h23, SW=6'h2B, BEQ=6'h04, BNE=6'h05, J=6'h02, JAL=6'h03);
  - funct constants (ADD=6'h20, ADDU=6'h21, SUB=6'h22, SUBU=6'h23, AND=6'h24, OR=6'h25, XOR=6'h26, NOR=6'h27, SLT=6'h2A, SLTU=6'h2B, SLL=0, SRL=2, SRA=3, SLLV=4, SRLV=6, SRAV=7, JR=8);
  - an FSM state enum.
- Sub-module inst_enc_word: purely combinational field-to-word encoder, reusable by the bench as its golden model.

Test Plan:
- start with base=0x010, len=1; op=ADD rs=1 rt=2 rd=3 -> one write 0x00221820 at addr 0x010, then done pulse, busy=0.
- len=4 stream of ADDI rs=1 rt=2 imm=5, LW rs=1 rt=2 imm=4, SLL rt=1 rd=2 shamt=3, J jimm=0x100 -> writes 0x20220005, 0x8C220004, 0x000110C0, 0x08000100 at consecutive addresses.
- imem_ready held low 5 cycles with in_valid continuously high -> in_ready drops once BUF_DEPTH words are buffered; no write lost or duplicated; data and address stable while stalled.
- base=2^ADDR_W-1, len=2 -> second write goes to addr 0 (wrap).
- prog_len=0 -> done one cycle after start, no imem_we.
- Illegal op 5'h1F mid-stream, then rst_n low one cycle mid-session:
  - with the macro: err=1 and 0xFFFFFFFF written;
  - without it: 0x00000000 written;
  - after reset: all outputs 0, back in IDLE.
